// File: rtl/mc0512_pkg.sv
// Shared types and defaults for the mc0512 core bus controller.
package mc0512_pkg;

    localparam int unsigned CNT_W = 8;
    localparam logic [19:0] ROM_BASE_DEFAULT = 20'hF0000;

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        RGN_RAM,
        RGN_ROM,
        RGN_IO
    } region_t;

endpackage

// File: rtl/mc0512_bus.sv
// Paces the 8088 core via cpu_ce and maps each core step onto one memory
// or I/O port access, with per-region wait states and an I/O read timeout.
module mc0512_bus
    import mc0512_pkg::*;
#(
    parameter int unsigned WS_RAM     = 0,
    parameter int unsigned WS_ROM     = 1,
    parameter logic [19:0] ROM_BASE   = ROM_BASE_DEFAULT,
    parameter int unsigned IO_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] cpu_address,
    input  logic [7:0]  cpu_out,
    input  logic        cpu_we,
    input  logic        cpu_pr,
    input  logic        cpu_pw,
    output logic [7:0]  cpu_in,
    output logic        cpu_ce,
    output logic [19:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] io_address,
    output logic [7:0]  io_wdata,
    output logic        io_rd,
    output logic        io_wr,
    input  logic [7:0]  io_rdata,
    input  logic        io_ready,
    output logic        io_timeout
);

    localparam logic [CNT_W-1:0] LOAD_RAM = CNT_W'(WS_RAM);
    localparam logic [CNT_W-1:0] LOAD_ROM = CNT_W'(WS_ROM);
    // The ISSUE cycle counts toward the I/O budget, so WAIT holds one cycle less.
    localparam logic [CNT_W-1:0] LOAD_IO  = CNT_W'((IO_TIMEOUT > 1) ? (IO_TIMEOUT - 1) : 0);

    state_t           state;
    region_t          region;
    region_t          req_region;
    logic             rd_req;
    logic             armed;
    logic             issue;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load;

    assign mem_address = cpu_address;
    assign mem_wdata   = cpu_out;
    assign io_address  = cpu_address[15:0];
    assign io_wdata    = cpu_out;

    // armed holds off the first ISSUE until one edge after reset releases.
    assign issue  = armed && (state == ST_ISSUE);
    assign mem_we = issue && cpu_we && (req_region == RGN_RAM);
    assign io_wr  = issue && cpu_pw;
    assign io_rd  = issue && cpu_pr && !cpu_pw;

    always_comb begin
        req_region = RGN_RAM;
        load       = LOAD_RAM;
        if (cpu_pw || cpu_pr) begin
            req_region = RGN_IO;
            load       = LOAD_IO;
        end else if (cpu_address >= ROM_BASE) begin
            req_region = RGN_ROM;
            load       = LOAD_ROM;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_ISSUE;
            region     <= RGN_RAM;
            rd_req     <= 1'b0;
            armed      <= 1'b0;
            cnt        <= '0;
            cpu_in     <= 8'h00;
            cpu_ce     <= 1'b0;
            io_timeout <= 1'b0;
        end else begin
            cpu_ce     <= 1'b0;
            io_timeout <= 1'b0;
            armed      <= 1'b1;
            case (state)
                ST_ISSUE: begin
                    if (armed) begin
                        region <= req_region;
                        rd_req <= cpu_pr && !cpu_pw;
                        cnt    <= load;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (region != RGN_IO) begin
                        cpu_in <= mem_rdata;
                        if (cnt == '0) begin
                            state  <= ST_DONE;
                            cpu_ce <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end else if (io_ready) begin
                        if (rd_req) cpu_in <= io_rdata;
                        state  <= ST_DONE;
                        cpu_ce <= 1'b1;
                    end else if (cnt <= CNT_W'(1)) begin
                        if (rd_req) cpu_in <= 8'hFF;
                        io_timeout <= 1'b1;
                        state      <= ST_DONE;
                        cpu_ce     <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_ISSUE;
                default: state <= ST_ISSUE;
            endcase
        end
    end

endmodule
